// File: rtl/lfsr_gen.sv
// lfsr_gen: maximal-length Fibonacci LFSR, 3..16 bits wide, advancing STEPS positions per
// enabled cycle, with zero-load lock-up protection. Define LFSR_GEN_WRAP_EN to build the wrap pulse.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             lock_err,
  output logic             wrap
);

  // Tap masks: bit (t-1) set for each tap position t of a primitive polynomial.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    logic [15:0] m;
    case (w)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0044;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_gen: WIDTH %0d outside 3..16", WIDTH);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS %0d outside 1..WIDTH", STEPS);
  end

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] stepped;
  logic             lock_err_q, lock_err_d;

  always_comb begin
    stepped = sreg_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      stepped = step1(stepped);
    end
  end

  // A rejected all-zero load falls back to SEED so the register can never lock up.
  always_comb begin
    sreg_d     = sreg_q;
    lock_err_d = 1'b0;
    if (load) begin
      if (load_val == '0) begin
        sreg_d     = SEED;
        lock_err_d = 1'b1;
      end else begin
        sreg_d = load_val;
      end
    end else if (en) begin
      sreg_d = stepped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= SEED;
      lock_err_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign dout     = sreg_q;
  assign lock_err = lock_err_q;

`ifdef LFSR_GEN_WRAP_EN
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q, wrap_d;

  // Only a step can signal a wrap; loads just re-arm the start value.
  always_comb begin
    start_d = start_q;
    wrap_d  = 1'b0;
    if (load) begin
      start_d = sreg_d;
    end else if (en) begin
      wrap_d = (stepped == start_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= SEED;
      wrap_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised maximal-length Fibonacci LFSR: the generalised successor to the fixed 7-bit pseudo-random source used by the lab's FSM/timer blocks.
- Width is selectable from 3 to 16 bits, using a built-in primitive-polynomial tap table.
- It can advance 1 to WIDTH positions per enabled cycle.
- It supports a synchronous seed load with protection against the all-zero lock-up state.
- An optional period-wrap indicator can be compiled in.
- It feeds random-delay and reaction-timer logic in the top level.

## Interface
- `WIDTH`, default 7: register width; legal range 3..16.
- `SEED`, default 1: reset and recovery value, WIDTH bits. Zero is illegal and causes an elaboration `$error`.
- `STEPS`, default 1: LFSR positions advanced per enabled cycle; legal range 1..WIDTH.
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `en`  in  1: advance the state by STEPS positions this cycle.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  WIDTH: value to load.
- `dout`  out  WIDTH: current state, driven directly from the register.
- `lock_err`  out  1: one-cycle pulse when a zero load was rejected.
- `wrap`  out  1: one-cycle pulse when the state returns to its start value. Tied to 0 when the macro in Configuration is absent.

## Operation
- State `sreg[WIDTH:1]` shifts left each position; the feedback bit enters `sreg[1]`.
- Feedback is the XOR of the tap bits. Taps per WIDTH:
  - 3: 3,2
  - 4: 4,3
  - 5: 5,3
  - 6: 6,5
  - 7: 7,3
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
  - 13: 13,4,3,1
  - 14: 14,5,3,1
  - 15: 15,14
  - 16: 16,15,13,4
- Each tap set gives a period of 2^WIDTH−1.
- One enabled cycle applies the single-position function STEPS times, combinationally unrolled, so `dout` moves STEPS positions per edge.
- Priority is: reset > `load` > `en` > hold.
- `load` with `load_val != 0`: `sreg <= load_val`; `en` is ignored that cycle.
- `load` with `load_val == 0`: `sreg <= SEED`, and `lock_err` pulses high for the following cycle.
- The all-zero state is therefore unreachable.
- The start value is an internal WIDTH-bit register. It is set to SEED at reset and to the accepted loaded value (or SEED) on every `load`.

## Timing
- Reset, asserted asynchronously: `dout = SEED`, `lock_err = 0`, `wrap = 0`, start value = SEED.
- Reset deassertion takes effect at the next rising edge. The first step happens on the first edge that sees `en = 1`.
- Latency: `en` sampled at edge k gives the new `dout` immediately after edge k. There are no pipeline stages.
- `load` sampled at edge k gives `dout = load_val` (or SEED) after edge k.
- `lock_err` is asserted for exactly the cycle after the rejected-load edge.
- `wrap` is asserted for exactly the cycle after an `en` step that lands `sreg` on the start value.
- A load never produces `wrap`, even when the loaded value equals the current state.
- `load` and `en` together: the load wins and no step occurs.
- With STEPS not coprime to 2^WIDTH−1, `wrap` still fires, after (2^WIDTH−1)/gcd cycles. Example: WIDTH=4, STEPS=3 wraps every 5 enabled cycles.
- Reset mid-operation: all state returns to reset values immediately; any pending `wrap`/`lock_err` pulse is cleared.

## Configuration
- Macro: `LFSR_GEN_WRAP_EN`.
- Defined: the start-value register, the compare logic and the registered `wrap` pulse are built as described above.
- Undefined:
  - The start-value register and comparator are not instantiated.
  - `wrap` is constant 0.
  - All other behaviour is unchanged.

## Test plan
- Seed and step sequence. Setup: WIDTH=4, SEED=1, STEPS=1, release reset, hold `en=1`.
  - Required `dout` after each edge: 2, 4, 9, 3, 6, 13, 10.
  - Period is 15.
  - With the macro defined, `wrap` pulses once per 15 cycles.
- Multi-step equivalence. Setup: WIDTH=4, STEPS=3, `en` held.
  - Required `dout`: 1 → 9 → 13.
  - After 5 enabled cycles `dout` is back to 1 and `wrap` pulses.
- Zero load. Setup: WIDTH=7, state 0x25, `load=1`, `load_val=0`.
  - Next `dout` is 1; `lock_err` is high for exactly one cycle.
  - Stepping continues 1 → 2 → 4.
- Load priority and start-value update. Setup: WIDTH=4, `load=1`, `en=1`, `load_val=6`.
  - `dout` is 6 with no step that cycle and no `wrap`.
  - After 15 further enabled cycles `dout` is 6 and `wrap` pulses.
- Async reset mid-run. Setup: WIDTH=8, assert `rst_n=0` between clock edges while `en=1`.
  - `dout` is 1 immediately, with no clock edge needed.
  - `wrap` and `lock_err` are 0.
  - Stepping resumes on the first edge after release.
- Maximal period. For WIDTH 3..16 with STEPS=1, run 2^WIDTH−1 enabled cycles.
  - No repeat of the start value before the final cycle.
  - `dout` is never 0.
